// File: rtl/icache_refill_axi_if.sv
// Refill port bundle: the cache-side line request/grant plus the AXI4 read channels.
// The master modport is the refill engine; the slave modport is its environment.
interface icache_refill_axi_if #(
    parameter int OFFSET_LEN = 5
);
    localparam int WORDS = 1 << (OFFSET_LEN - 2);

    logic                   mem_read_req;
    logic [31:0]            mem_addr;
    logic                   mem_gnt;
    logic [WORDS-1:0][31:0] ins;
    logic                   refill_err;

    logic [3:0]             arid;
    logic [31:0]            araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [3:0]             rid;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport master (
        input  mem_read_req, mem_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output mem_gnt, ins, refill_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output mem_read_req, mem_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  mem_gnt, ins, refill_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/icache_refill_axi.sv
// ICache line-refill engine: one AXI4 INCR burst per request, words assembled into a line buffer.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid never depends on ready.
module icache_refill_axi #(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    icache_refill_axi_if.master    bus,
    output logic [1:0]             state_o
);
    localparam int WORDS = 1 << (OFFSET_LEN - 2);
    localparam int CW    = OFFSET_LEN - 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [31:0]            araddr_q, araddr_d;
    logic [WORDS-1:0][31:0] ins_q, ins_d;
    logic                   last_idx;

    assign last_idx = (cnt_q == CW'(WORDS - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        araddr_d = araddr_q;
        ins_d    = ins_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read_req) begin
                    araddr_d = {bus.mem_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = AR;
                end
            end
            AR: begin
                if (bus.arready) state_d = R;
            end
            R: begin
                // rready is high for the whole of R, so rvalid alone marks a beat.
                if (bus.rvalid) begin
                    ins_d[cnt_q] = bus.rdata;
                    cnt_d        = cnt_q + 1'b1;
                    if (bus.rresp != 2'b00) err_d = 1'b1;
                    if (bus.rlast) begin
                        if (!last_idx) err_d = 1'b1;
                        state_d = DONE;
                    end else if (last_idx) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            araddr_q <= '0;
            ins_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            araddr_q <= araddr_d;
            ins_q    <= ins_d;
        end
    end

    assign bus.arvalid    = (state_q == AR);
    assign bus.rready     = (state_q == R);
    assign bus.mem_gnt    = (state_q == DONE);
    assign bus.refill_err = (state_q == DONE) && err_q;
    assign bus.ins        = ins_q;
    assign bus.araddr     = araddr_q;
    assign bus.arid       = AXI_ID;
    assign bus.arlen      = 8'(WORDS - 1);
    assign bus.arsize     = 3'b010;
    assign bus.arburst    = 2'b01;
    assign state_o        = state_q;

    logic unused_bits;
    assign unused_bits = ^{bus.rid, bus.mem_addr[OFFSET_LEN-1:0]};
endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed bench for icache_refill_axi: a transaction-level line model feeds an expected queue
// that a per-cycle compare process checks at every grant and on every address-valid cycle.
module tb_icache_refill_axi;
    localparam int OL    = 5;
    localparam int WORDS = 8;
    localparam int LW    = WORDS * 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state;

    always #5 clk = ~clk;

    icache_refill_axi_if #(.OFFSET_LEN(OL)) bus ();

    icache_refill_axi #(.OFFSET_LEN(OL), .AXI_ID(4'd0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          gnt_seen = 0;
    logic [LW-1:0] exp_q[$];
    logic        exp_err_q[$];
    logic [31:0] exp_line [WORDS];
    logic [31:0] exp_araddr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_line();
        logic [LW-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = exp_line[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.arvalid) begin
                chk("araddr", bus.araddr, exp_araddr);
                chk("ar_fields", {bus.arid, bus.arlen, bus.arsize, bus.arburst},
                    {4'd0, 8'd7, 3'd2, 2'd1});
            end
            if (bus.mem_gnt) begin
                gnt_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_gnt: got gnt at cycle %0d want none", cyc);
                end else begin
                    chk("ins_line", bus.ins, exp_q.pop_front());
                    chk("refill_err", bus.refill_err, exp_err_q.pop_front());
                end
            end else begin
                chk("refill_err_idle", bus.refill_err, 1'b0);
            end
        end
    end

    // last_at < 0: slave never asserts rlast; err_at < 0: all responses OKAY.
    task automatic refill(input logic [31:0] addr, input logic [31:0] seed, input int ar_wait,
                          input int last_at, input int err_at, input bit gaps, input bit keep,
                          input logic [31:0] next_addr);
        int   acc;
        int   c0;
        logic err;
        bit   found;
        acc = (last_at >= 0) ? last_at + 1 : WORDS;
        err = (last_at != WORDS - 1) || (err_at >= 0 && err_at < acc);
        for (int k = 0; k < acc; k++) exp_line[k] = seed + k;
        exp_q.push_back(pack_line());
        exp_err_q.push_back(err);
        exp_araddr = {addr[31:OL], {OL{1'b0}}};

        bus.mem_read_req = 1'b1;
        bus.mem_addr     = addr;
        bus.arready      = (ar_wait == 0);
        c0 = cyc;
        tick();
        bus.mem_addr = ~addr;
        if (ar_wait > 0) begin
            repeat (ar_wait) tick();
            bus.arready = 1'b1;
        end
        tick();
        bus.arready = 1'b0;
        if (!keep) bus.mem_read_req = 1'b0;

        for (int k = 0; k < acc; k++) begin
            if (gaps && k > 0) begin
                bus.rvalid = 1'b0;
                tick();
            end
            bus.rvalid = 1'b1;
            bus.rdata  = seed + k;
            bus.rresp  = (k == err_at) ? 2'b10 : 2'b00;
            bus.rlast  = (k == last_at);
            tick();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        if (last_at < 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hDEAD_BEEF;
            chk("rready_after_long", bus.rready, 1'b0);
        end

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_gnt) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL gnt_timeout: got no gnt for addr %0h want one", addr);
        end else if (ar_wait == 0 && !gaps && last_at == WORDS - 1) begin
            chk("gnt_latency", cyc - c0, 10);
        end
        bus.rvalid   = 1'b0;
        bus.mem_addr = keep ? next_addr : 32'h0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_read_req = 1'b0;
        bus.mem_addr     = '0;
        bus.arready      = 1'b0;
        bus.rid          = 4'd0;
        bus.rdata        = '0;
        bus.rresp        = 2'b00;
        bus.rlast        = 1'b0;
        bus.rvalid       = 1'b0;
        for (int i = 0; i < WORDS; i++) exp_line[i] = '0;

        repeat (3) tick();
        chk("rst_state", state, 2'd0);
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_gnt", bus.mem_gnt, 1'b0);
        chk("rst_err", bus.refill_err, 1'b0);
        chk("rst_ins", bus.ins, '0);
        chk("rst_araddr", bus.araddr, 32'h0);
        rst = 1'b0;
        tick();

        refill(32'hBFC0_0024, 32'h1000, 0, 7, -1, 1'b0, 1'b0, 32'h0);
        chk("basic_araddr", bus.araddr, 32'hBFC0_0020);
        chk("basic_ins0", bus.ins[0], 32'h0000_1000);
        chk("basic_ins7", bus.ins[7], 32'h0000_1007);

        refill(32'h8000_1040, 32'h2000, 3, 7, -1, 1'b1, 1'b0, 32'h0);
        chk("bp_ins5", bus.ins[5], 32'h0000_2005);

        refill(32'h8000_2000, 32'h3000, 0, 7, 3, 1'b0, 1'b0, 32'h0);
        refill(32'h8000_3000, 32'h4000, 1, 7, -1, 1'b0, 1'b0, 32'h0);

        refill(32'h8000_4000, 32'h7000, 0, 5, -1, 1'b0, 1'b0, 32'h0);
        chk("short_ins5", bus.ins[5], 32'h0000_7005);
        chk("short_ins6", bus.ins[6], 32'h0000_4006);
        chk("short_ins7", bus.ins[7], 32'h0000_4007);

        refill(32'h8000_5000, 32'h8000, 0, -1, -1, 1'b0, 1'b0, 32'h0);

        exp_araddr       = 32'h0000_4000;
        bus.mem_read_req = 1'b1;
        bus.mem_addr     = 32'h0000_4010;
        bus.arready      = 1'b1;
        tick();
        tick();
        bus.arready      = 1'b0;
        bus.mem_read_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'h5000 + k;
            tick();
        end
        bus.rvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", state, 2'd0);
        chk("mid_rst_rready", bus.rready, 1'b0);
        chk("mid_rst_arvalid", bus.arvalid, 1'b0);
        chk("mid_rst_gnt", bus.mem_gnt, 1'b0);
        chk("mid_rst_ins", bus.ins, '0);
        for (int i = 0; i < WORDS; i++) exp_line[i] = '0;
        tick();

        refill(32'h0000_6004, 32'h6000, 0, 7, -1, 1'b0, 1'b0, 32'h0);
        chk("post_rst_ins3", bus.ins[3], 32'h0000_6003);

        refill(32'h1111_1100, 32'h9000, 0, 7, -1, 1'b0, 1'b1, 32'h2222_2200);
        refill(32'h2222_2200, 32'hA000, 0, 7, -1, 1'b0, 1'b0, 32'h0);
        chk("b2b_araddr", bus.araddr, 32'h2222_2200);

        repeat (4) tick();
        chk("gnt_count", gnt_seen, 9);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
- Memory-side responder for the instruction cache's line-refill port.
- Accepts a line read request (mem_read_req / mem_addr) from the cache and issues one AXI4 INCR burst read.
- Assembles the returned words into a line buffer, then pulses mem_gnt with the full line presented on ins.
- Sits between the ICache and the AXI interconnect; read-only, one outstanding transaction.

Parameters:
- OFFSET_LEN, 5, line offset bits; line = 1<<(OFFSET_LEN-2) words (8 words, 32 B)
- AXI_ID, 0, constant ARID value (4 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_read_req  in  1  cache line-fill request, held high until mem_gnt
- mem_addr  in  32  line address; low OFFSET_LEN bits ignored
- mem_gnt  out  1  one-cycle pulse: ins holds the complete line
- ins  out  32 x (1<<(OFFSET_LEN-2))  line buffer, word i = address base+4i
- refill_err  out  1  one-cycle pulse with mem_gnt when the burst had RRESP!=0 or a length mismatch
- arid  out  4  = AXI_ID
- araddr  out  32  {mem_addr[31:OFFSET_LEN], OFFSET_LEN'b0}
- arlen  out  8  = (1<<(OFFSET_LEN-2))-1
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data ready

Behaviour:
- Reset (synchronous, on clk rising edge with rst=1):
  - state=IDLE; arvalid=0, rready=0, mem_gnt=0, refill_err=0.
  - Word counter=0, err flag=0; araddr=0; ins cleared to 0.
  - Reset mid-burst abandons the transaction (system reset is shared with the slave).
- States: IDLE, AR, R, DONE.
- IDLE:
  - If mem_read_req=1: latch araddr from mem_addr, clear counter and err flag, assert arvalid, go to AR.
  - Otherwise stay in IDLE.
- AR:
  - Hold arvalid and araddr stable until arready=1.
  - On the arvalid&arready cycle: arvalid deasserts next cycle, rready asserts next cycle, go to R.
  - araddr must not change while arvalid=1, even if mem_addr changes.
- R:
  - rready=1 throughout.
  - Each beat (rvalid&rready): ins[cnt]<=rdata, cnt<=cnt+1; rresp!=0 sets the err flag.
  - Beat with rlast=1: go to DONE. If cnt != last index, set the err flag (short burst); unfilled words keep their previous contents.
  - Beat with cnt == last index and rlast=0: set the err flag, go to DONE (long burst; rready drops, excess beats are not accepted).
  - Beats with rvalid=0 cause no change (back-pressure from the slave is allowed).
- DONE:
  - mem_gnt=1 for exactly one cycle; refill_err=err flag in the same cycle; rready=0; go to IDLE.
- Line stability: ins is stable from the mem_gnt cycle until the first accepted beat of the next transaction, so the cache can write its banks in the cycle after mem_gnt.
- Request ordering: the cache drops mem_read_req the cycle after mem_gnt. IDLE samples the request only from the cycle after DONE, so one request gives exactly one burst. A request still high after DONE starts a new burst; this is legal.
- Latency, zero-wait slave: request seen in IDLE at cycle 0 → arvalid at cycle 1 → R at cycle 2 → 8 beats on cycles 2–9 → mem_gnt at cycle 10.
- mem_read_req deasserting mid-transaction has no effect: the burst completes and mem_gnt still pulses.
- No reads are issued except through mem_read_req; only one transaction is in flight at a time.

Test Plan:
- Basic refill: mem_read_req=1, mem_addr=0xBFC0_0024; slave with arready=1 and beats 0x1000+i, i=0..7, rlast on beat 7 → araddr=0xBFC0_0020, arlen=7, arsize=2, arburst=1; ins[i]=0x1000+i; one-cycle mem_gnt 10 cycles after the request; refill_err=0.
- Back-pressure: arready held 0 for 3 cycles, then rvalid toggled 1,0,1,0 → arvalid and araddr stable while waiting; only valid beats are stored; ins correct; exactly one mem_gnt.
- Error response: beat 3 returns rresp=2'b10 → all 8 words still captured; refill_err=1 in the mem_gnt cycle; next clean refill gives refill_err=0.
- Short burst: rlast on beat 5 → DONE after 6 beats; refill_err=1; ins[6..7] keep their old values. Long burst: rlast never asserted → rready=0 after beat 8; refill_err=1.
- Reset mid-burst: rst=1 after beat 4 → next cycle state=IDLE, rready=0, arvalid=0, mem_gnt=0, ins=0. A new request then completes normally.
- Back-to-back: mem_read_req held high across mem_gnt for one extra cycle → a second AR is issued with the new address; each burst produces exactly one mem_gnt.
